// File: rtl/firebird7_in_gate1_ijtag_pkg.sv
// Shared IJTAG types and constants for the gate1 instrument network.
package firebird7_in_gate1_ijtag_pkg;

  localparam int unsigned TDR_MAX_WIDTH = 32;

  // Spare/redundancy TDR defaults
  localparam int unsigned SPARE_RED_WIDTH        = 8;
  localparam logic [7:0]  SPARE_RED_RESET_VALUE  = 8'h00;
  localparam logic [7:0]  SPARE_RED_CAPTURE_MASK = 8'hF0;

  // IJTAG control strobes as seen by a TDR or SIB
  typedef struct packed {
    logic ce;
    logic se;
    logic ue;
    logic sel;
  } ijtag_ctrl_t;

endpackage

// File: rtl/firebird7_in_gate1_tessent_so_retime_latch.sv
// Negative-level scan-out latch: half-cycle retime of the last scan bit.
module firebird7_in_gate1_tessent_so_retime_latch (
  input  logic tck_i,
  input  logic d_i,
  output logic q_o
);

  // Transparent while tck is low, holds through the high phase
  always_latch begin
    if (!tck_i) q_o <= d_i;
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_spare_red.sv
// Spare/redundancy TDR below the gate1 SIB: shift/capture, negedge update,
// sticky status bits and a self-clearing go pulse.
module firebird7_in_gate1_tessent_tdr_spare_red
  import firebird7_in_gate1_ijtag_pkg::*;
#(
  parameter int unsigned       WIDTH        = SPARE_RED_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VALUE  = WIDTH'(SPARE_RED_RESET_VALUE),
  parameter logic [WIDTH-1:0]  CAPTURE_MASK = WIDTH'(SPARE_RED_CAPTURE_MASK),
  parameter int unsigned       PULSE_BIT    = 0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_si,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] status_in,
  output logic [WIDTH-1:0] data_out,
  output logic             go_pulse
);

  localparam logic [WIDTH-1:0] PULSE_ONEHOT = WIDTH'(1) << PULSE_BIT;
  // Sticky flops only exist where capture reports status, never on the go bit
  localparam logic [WIDTH-1:0] STICKY_MASK  = CAPTURE_MASK & ~PULSE_ONEHOT;

  ijtag_ctrl_t ctrl_c;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [WIDTH-1:0] upd_q, upd_d;
  logic             go_q, go_d;
  logic [WIDTH-1:0] cap_word_c;

  assign ctrl_c = '{ce: ijtag_ce, se: ijtag_se, ue: ijtag_ue, sel: ijtag_sel};

  // Capture word; same-cycle status is folded in so a clear loses nothing
  always_comb begin
    cap_word_c = ((sticky_q | status_in) & STICKY_MASK)
               | (upd_q & ~CAPTURE_MASK & ~PULSE_ONEHOT);
  end

  // Shift-register and sticky next state; capture beats shift
  always_comb begin
    sr_d     = sr_q;
    sticky_d = (sticky_q | status_in) & STICKY_MASK;
    if (ctrl_c.ce && ctrl_c.sel) begin
      sr_d     = cap_word_c;
      sticky_d = '0;
    end else if (ctrl_c.se && ctrl_c.sel) begin
      sr_d = {ijtag_si, sr_q[WIDTH-1:1]};
    end
  end

  // Update register and go pulse next state
  always_comb begin
    upd_d = upd_q;
    go_d  = 1'b0;
    if (ctrl_c.ue && ctrl_c.sel) begin
      upd_d = sr_q & ~PULSE_ONEHOT;
      go_d  = |(sr_q & PULSE_ONEHOT);
    end
  end

  // Shift register, unreset like the SIB scan flop
  always_ff @(posedge ijtag_tck) begin
    sr_q <= sr_d;
  end

  // Sticky status accumulation
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) sticky_q <= '0;
    else              sticky_q <= sticky_d;
  end

  // Shadow/update stage on the falling edge
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      upd_q <= RESET_VALUE & ~PULSE_ONEHOT;
      go_q  <= 1'b0;
    end else begin
      upd_q <= upd_d;
      go_q  <= go_d;
    end
  end

  assign data_out = upd_q;
  assign go_pulse = go_q;

  firebird7_in_gate1_tessent_so_retime_latch u_so_latch (
    .tck_i (ijtag_tck),
    .d_i   (sr_q[0]),
    .q_o   (ijtag_so)
  );

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_spare_red.sv
// Directed plus randomized bench for the spare/redundancy TDR.
module tb_firebird7_in_gate1_tessent_tdr_spare_red;

  localparam logic [7:0] MASK  = 8'hF0;
  localparam logic [7:0] RVAL  = 8'h00;

  logic       ijtag_tck = 1'b0;
  logic       ijtag_reset = 1'b0;
  logic       ijtag_sel = 1'b0, ijtag_si = 1'b0;
  logic       ijtag_ce = 1'b0, ijtag_se = 1'b0, ijtag_ue = 1'b0;
  logic       ijtag_so;
  logic [7:0] status_in = 8'h00;
  logic [7:0] data_out;
  logic       go_pulse;

  int checks = 0;
  int failures = 0;

  // Transaction-level reference state
  logic [7:0] m_upd    = RVAL;  // expected data_out
  logic [7:0] m_events = 8'h00; // status events seen since the last capture
  logic [7:0] m_sr     = 8'h00; // word last captured or shifted in

  logic       so_s, go_s;
  logic [7:0] dout_s;

  firebird7_in_gate1_tessent_tdr_spare_red dut (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .ijtag_sel   (ijtag_sel),
    .ijtag_si    (ijtag_si),
    .ijtag_ce    (ijtag_ce),
    .ijtag_se    (ijtag_se),
    .ijtag_ue    (ijtag_ue),
    .ijtag_so    (ijtag_so),
    .status_in   (status_in),
    .data_out    (data_out),
    .go_pulse    (go_pulse)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One TCK period; outputs sampled just after the falling edge
  task automatic tick();
    @(negedge ijtag_tck); #1;
    so_s   = ijtag_so;
    go_s   = go_pulse;
    dout_s = data_out;
    if (ijtag_reset) begin
      if (ijtag_ce && ijtag_sel) m_events = 8'h00;
      else                       m_events = m_events | (status_in & MASK);
    end
    @(posedge ijtag_tck); #1;
  endtask

  task automatic capture();
    logic [7:0] exp;
    exp = ((m_events | status_in) & MASK) | (m_upd & ~MASK);
    ijtag_ce = 1'b1; ijtag_se = 1'b0; ijtag_ue = 1'b0;
    tick();
    ijtag_ce = 1'b0;
    m_sr = exp;
  endtask

  task automatic shift(input logic [7:0] win, output logic [7:0] wout);
    ijtag_se = 1'b1; ijtag_ce = 1'b0; ijtag_ue = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ijtag_si = win[i];
      tick();
      wout[i] = so_s;
    end
    ijtag_se = 1'b0;
    m_sr = win;
  endtask

  task automatic update(input string tag);
    ijtag_ue = 1'b1; ijtag_ce = 1'b0; ijtag_se = 1'b0;
    tick();
    ijtag_ue = 1'b0;
    m_upd = m_sr & 8'hFE;
    check({tag, "_dout"}, 32'(dout_s), 32'(m_upd));
    check({tag, "_go"},   32'(go_s),   32'(m_sr[0]));
  endtask

  task automatic cap_and_check(input string tag, output logic [7:0] got);
    logic [7:0] exp;
    capture();
    exp = m_sr;
    shift(8'h00, got);
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    logic [7:0] w, o, hold;

    // 1: reset, then capture zero status
    tick(); tick();
    check("rst_dout", 32'(data_out), 32'(RVAL));
    check("rst_go",   32'(go_pulse), 32'h0);
    ijtag_reset = 1'b1;
    ijtag_sel   = 1'b1;
    cap_and_check("t1_cap", o);
    check("t1_cap_const", 32'(o), 32'h00);
    check("t1_dout", 32'(data_out), 32'h00);
    check("t1_go",   32'(go_pulse), 32'h0);

    // 2: load 5A, read back through capture
    shift(8'h5A, o);
    update("t2_upd");
    cap_and_check("t2_cap", o);
    check("t2_cap_const", 32'(o), 32'h0A);

    // 3: go pulse, single then back-to-back
    shift(8'h01, o);
    update("t3_upd");
    tick();
    check("t3_go_off", 32'(go_s), 32'h0);
    shift(8'h01, o);
    update("t3_upd_a");
    update("t3_upd_b");
    tick();
    check("t3_go_off2", 32'(go_s), 32'h0);

    // 4: sticky event survives idle cycles, then clears on capture
    status_in = 8'h20; tick(); status_in = 8'h00;
    repeat (10) tick();
    cap_and_check("t4_cap1", o);
    check("t4_bit5_set", 32'(o[5]), 32'h1);
    cap_and_check("t4_cap2", o);
    check("t4_bit5_clr", 32'(o[5]), 32'h0);

    // 5: event in the capture cycle itself
    status_in = 8'h80;
    capture();
    status_in = 8'h00;
    w = m_sr;
    shift(8'h00, o);
    check("t5_cap", 32'(o), 32'(w));
    check("t5_bit7", 32'(o[7]), 32'h1);
    cap_and_check("t5_after", o);
    check("t5_bit7_clr", 32'(o[7]), 32'h0);

    // Randomized: load, update, status traffic, capture and compare
    for (int n = 0; n < 24; n++) begin
      w = 8'($urandom);
      shift(w, o);
      update($sformatf("rnd%0d_upd", n));
      repeat ($urandom_range(0, 3)) begin
        status_in = 8'($urandom);
        tick();
      end
      status_in = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      capture();
      status_in = 8'h00;
      w = m_sr;
      shift(8'($urandom), o);
      check($sformatf("rnd%0d_cap", n), 32'(o), 32'(w));
    end

    // 6: deselected activity must not disturb anything
    shift(8'h5A, o);
    update("t6_load");
    w = 8'hC3;
    shift(w, o);
    hold = data_out;
    ijtag_sel = 1'b0;
    for (int n = 0; n < 20; n++) begin
      ijtag_ce = 1'($urandom); ijtag_se = 1'($urandom);
      ijtag_ue = 1'($urandom); ijtag_si = 1'($urandom);
      tick();
      check("t6_dout_hold", 32'(dout_s), 32'(hold));
      check("t6_go_low",    32'(go_s),   32'h0);
    end
    ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0;
    ijtag_sel = 1'b1;
    shift(8'h00, o);
    check("t6_sr_hold", 32'(o), 32'(w));

    // Reset mid-shift clears update and sticky immediately
    status_in = 8'h40; tick(); status_in = 8'h00;
    ijtag_se = 1'b1;
    repeat (3) begin ijtag_si = 1'($urandom); tick(); end
    ijtag_reset = 1'b0;
    #1;
    check("rst_mid_dout", 32'(data_out), 32'(RVAL));
    check("rst_mid_go",   32'(go_pulse), 32'h0);
    m_upd = RVAL; m_events = 8'h00;
    #2 ijtag_reset = 1'b1;
    ijtag_se = 1'b0;
    @(posedge ijtag_tck); #1;
    cap_and_check("rst_mid_cap", o);
    check("rst_mid_sticky", 32'(o[6]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
